// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding, vector count and reference truth tables for gate_bist_checker
package gate_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VEC = 4;
  localparam logic [3:0] NOR_TT = 4'b0001;
  localparam logic [3:0] AND_TT = 4'b1000;
  localparam logic [3:0] OR_TT = 4'b1110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] XOR_TT = 4'b0110;
endpackage

// File: rtl/gate_bist_settle_timer.sv
// gate_bist_settle_timer: loadable down-counter that stops at zero and flags it
module gate_bist_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: applies all four {a,b} vectors to a 2-input cell and checks c against EXP_TT.
// Define GATE_BIST_STOP_ON_FAIL_EN to end the run at the first mismatching sample.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter logic [3:0] EXP_TT = NOR_TT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               a_o,
  output logic               b_o,
  input  logic               c_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] err_vec,
  output logic [2:0]         fail_cnt
);
  state_t state, state_n;
  logic [1:0] vec_idx, vec_idx_n;
  logic [NUM_VEC-1:0] err_vec_n;
  logic [2:0] fail_cnt_n;
  logic zero, accept, sample, mismatch, last;
  assign accept = state != RUN && start;
  assign sample = state == RUN && zero;
  assign mismatch = c_i != EXP_TT[vec_idx];
`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign last = vec_idx == 2'd3 || mismatch;
`else
  assign last = vec_idx == 2'd3;
`endif
  gate_bist_settle_timer #(.W(4)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept || (sample && !last)),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .zero     (zero)
  );
  // Outputs derive from registered state so reset clears them without waiting for clk
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_vec == '0;
  assign a_o = busy && vec_idx[1];
  assign b_o = busy && vec_idx[0];
  always_comb begin
    state_n = accept ? RUN : (sample && last) ? DONE : state;
    vec_idx_n = accept ? 2'd0 : (sample && !last) ? vec_idx + 2'd1 : vec_idx;
    err_vec_n = accept ? '0 : (sample && mismatch) ? err_vec | (4'b1 << vec_idx) : err_vec;
    fail_cnt_n = accept ? 3'd0 : (sample && mismatch) ? fail_cnt + 3'd1 : fail_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vec_idx <= 2'd0;
      err_vec <= '0;
      fail_cnt <= 3'd0;
    end else begin
      state <= state_n;
      vec_idx <= vec_idx_n;
      err_vec <= err_vec_n;
      fail_cnt <= fail_cnt_n;
    end
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: directed runs against NOR, OR and a vector-2-faulty cell, plus restart and async reset
module tb_gate_bist_checker;
  import gate_bist_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, a_o, b_o, c_i, busy, done, pass;
  logic [3:0] err_vec;
  logic [2:0] fail_cnt;
  int mode = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // mode 0: NOR, mode 1: OR, mode 2: output 1 only on vector {a,b}=10
  always_comb c_i = mode == 0 ? ~(a_o | b_o) : mode == 1 ? (a_o | b_o) : (a_o & ~b_o);
  gate_bist_checker #(.SETTLE_CYCLES(2), .EXP_TT(NOR_TT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o), .c_i(c_i),
    .busy(busy), .done(done), .pass(pass), .err_vec(err_vec), .fail_cnt(fail_cnt)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, " outs"}, {1'b0, a_o, b_o, busy, done, pass, 2'b0}, 8'h00);
    chk({tag, " err_vec"}, 8'(err_vec), 8'h00);
    chk({tag, " fail_cnt"}, 8'(fail_cnt), 8'h00);
  endtask
  task automatic do_run(input string tag, input logic [3:0] exp_err, input logic [2:0] exp_cnt,
                        input int done_at, input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " start busy/done"}, {6'b0, busy, done}, 8'h02);
    chk({tag, " start cleared"}, {1'b0, fail_cnt, err_vec}, 8'h00);
    chk({tag, " start ab"}, {6'b0, a_o, b_o}, 8'h00);
    for (int t = 1; t <= done_at; t++) begin
      start = poke && t == 3;
      step();
      start = 1'b0;
      if (t < done_at) begin
        chk($sformatf("%s t%0d busy/done", tag, t), {6'b0, busy, done}, 8'h02);
        chk($sformatf("%s t%0d ab", tag, t), {6'b0, a_o, b_o}, 8'(t / 2));
      end
    end
    chk({tag, " end busy/done/pass"}, {5'b0, busy, done, pass}, {5'b0, 1'b0, 1'b1, exp_err == 4'b0});
    chk({tag, " end err_vec"}, 8'(err_vec), 8'(exp_err));
    chk({tag, " end fail_cnt"}, 8'(fail_cnt), 8'(exp_cnt));
    chk({tag, " end ab"}, {6'b0, a_o, b_o}, 8'h00);
  endtask
  initial begin
    #2;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    all_zero("idle");
    mode = 0;
    do_run("nor", 4'b0000, 3'd0, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done hold", {4'b0, busy, done, pass, 1'b0}, 8'h06);
    end
    mode = 1;
    do_run("or", 4'b1111, 3'd4, 8, 1'b0);
    step();
    chk("or err stable", 8'(err_vec), 8'h0f);
    mode = 2;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    do_run("vec2", 4'b0001, 3'd1, 2, 1'b0);
`else
    do_run("vec2", 4'b0101, 3'd2, 8, 1'b0);
`endif
    mode = 0;
    do_run("poke", 4'b0000, 3'd0, 8, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre-reset ab", {6'b0, a_o, b_o}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    all_zero("post reset");
    do_run("clean", 4'b0000, 3'd0, 8, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
